// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro: RF_R0_ZERO_EN (hardwired-zero r0).
package rf_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Decode a register index into a pending-vector bit.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side handshake bundle for the writeback arbiter.
// master = the two writeback stages, slave = the arbiter.
interface regfile_wb_arbiter_if;
  import rf_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_prio_arb.sv
// Fixed-priority (MEM first) grant logic with an ALU starvation counter.
// After STARVE_MAX consecutive MEM grants with the ALU waiting, the ALU wins.
module wb_prio_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_ready,
  output logic mem_ready
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       alu_starved;

  // Grant selection; readys are forced low while reset is asserted.
  always_comb begin
    alu_starved = (starve_cnt == STARVE_LIM);
    mem_ready   = 1'b0;
    alu_ready   = 1'b0;
    if (!rst) begin
      mem_ready = mem_valid && !(alu_valid && alu_starved);
      alu_ready = alu_valid && !mem_ready;
    end
  end

  // Count MEM grants that overtook a waiting ALU request, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      starve_cnt <= '0;
    end else if (mem_ready && !alu_starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: two writeback requesters share one
// registered write port; exports a pending-write vector for hazard checks.
// Optional feature macro: RF_R0_ZERO_EN (r0 hardwired to zero).
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave wb,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   write_data,
  output logic                grant_src,
  output logic [NUM_REGS-1:0] pending
);

  wb_req_t alu_req;
  wb_req_t mem_req;
  wb_req_t sel_req;
  logic    take;
  logic    alu_ready;
  logic    mem_ready;
  wb_src_t src_q;

  wb_prio_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (wb.alu_valid),
    .mem_valid (wb.mem_valid),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready)
  );

  assign wb.alu_ready = alu_ready;
  assign wb.mem_ready = mem_ready;

  // Bundle requests and pick the granted one.
  always_comb begin
    alu_req = '{valid: wb.alu_valid, rd: wb.alu_rd, data: wb.alu_data};
    mem_req = '{valid: wb.mem_valid, rd: wb.mem_rd, data: wb.mem_data};
    sel_req = mem_ready ? mem_req : alu_req;
    take    = (alu_ready && alu_req.valid) || (mem_ready && mem_req.valid);
  end

  // Registered write port; address/data/source hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      src_q      <= SRC_ALU;
    end else if (take) begin
`ifdef RF_R0_ZERO_EN
      reg_write  <= (sel_req.rd != '0);
`else
      reg_write  <= 1'b1;
`endif
      rd         <= sel_req.rd;
      write_data <= sel_req.data;
      src_q      <= mem_ready ? SRC_MEM : SRC_ALU;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  assign grant_src = src_q;

  // Pending-write decode over live requests and the write on the port.
  always_comb begin
    pending = '0;
    if (wb.alu_valid) pending = pending | onehot(wb.alu_rd);
    if (wb.mem_valid) pending = pending | onehot(wb.mem_rd);
    if (reg_write)    pending = pending | onehot(rd);
`ifdef RF_R0_ZERO_EN
    pending[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  logic                clk;
  logic                rst;
  logic                reg_write;
  logic [ADDR_W-1:0]   rd;
  logic [DATA_W-1:0]   write_data;
  logic                grant_src;
  logic [NUM_REGS-1:0] pending;

  int unsigned n_vec;
  int unsigned n_mis;

  regfile_wb_arbiter_if wb ();

  regfile_wb_arbiter #(
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .grant_src  (grant_src),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.alu_valid = 1'b0;
    wb.alu_rd    = '0;
    wb.alu_data  = '0;
    wb.mem_valid = 1'b0;
    wb.mem_rd    = '0;
    wb.mem_data  = '0;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    idle_inputs();
    rst = 1'b1;
    #2;

    // Reset state, readys held low even with requests present
    wb.alu_valid = 1'b1;
    wb.mem_valid = 1'b1;
    #1;
    check_eq("rst_reg_write", 32'(reg_write), 32'd0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_write_data", write_data, 32'd0);
    check_eq("rst_grant_src", 32'(grant_src), 32'd0);
    check_eq("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
    check_eq("rst_mem_ready", 32'(wb.mem_ready), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-write: ALU rd=7 goes onto the port, then reset drops it
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd7;
    wb.alu_data  = 32'h0000_0077;
    tick();
    idle_inputs();
    check_eq("midrst_pre_reg_write", 32'(reg_write), 32'd1);
    check_eq("midrst_pre_rd", 32'(rd), 32'd7);
    wb.alu_valid = 1'b1;
    wb.mem_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_reg_write", 32'(reg_write), 32'd0);
    check_eq("midrst_rd", 32'(rd), 32'd0);
    check_eq("midrst_alu_ready", 32'(wb.alu_ready), 32'd0);
    check_eq("midrst_mem_ready", 32'(wb.mem_ready), 32'd0);
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();

    // Single ALU request rd=3
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd3;
    wb.alu_data  = 32'hDEAD_BEEF;
    #1;
    check_eq("alu1_ready", 32'(wb.alu_ready), 32'd1);
    check_eq("alu1_mem_ready", 32'(wb.mem_ready), 32'd0);
    check_eq("alu1_pending_n", pending, 32'h0000_0008);
    tick();
    idle_inputs();
    #1;
    check_eq("alu1_reg_write", 32'(reg_write), 32'd1);
    check_eq("alu1_rd", 32'(rd), 32'd3);
    check_eq("alu1_write_data", write_data, 32'hDEAD_BEEF);
    check_eq("alu1_grant_src", 32'(grant_src), 32'd0);
    check_eq("alu1_pending_n1", pending, 32'h0000_0008);
    tick();
    check_eq("alu1_idle_reg_write", 32'(reg_write), 32'd0);
    check_eq("alu1_idle_rd_hold", 32'(rd), 32'd3);
    check_eq("alu1_idle_data_hold", write_data, 32'hDEAD_BEEF);
    check_eq("alu1_pending_clear", pending, 32'h0000_0000);

    // Single MEM request rd=12
    wb.mem_valid = 1'b1;
    wb.mem_rd    = 5'd12;
    wb.mem_data  = 32'h0000_00A5;
    #1;
    check_eq("mem1_ready", 32'(wb.mem_ready), 32'd1);
    tick();
    idle_inputs();
    check_eq("mem1_reg_write", 32'(reg_write), 32'd1);
    check_eq("mem1_rd", 32'(rd), 32'd12);
    check_eq("mem1_write_data", write_data, 32'h0000_00A5);
    check_eq("mem1_grant_src", 32'(grant_src), 32'd1);
    tick();

    // Both valid for 10 cycles: MEM x4 then ALU, repeating
    wb.alu_valid = 1'b1;
    wb.mem_valid = 1'b1;
    wb.alu_rd    = 5'd1;
    wb.mem_rd    = 5'd2;
    for (int i = 0; i < 10; i++) begin
      logic exp_mem;
      exp_mem = ((i % 5) != 4);
      wb.alu_data = 32'h1000_0000 + 32'(i);
      wb.mem_data = 32'h2000_0000 + 32'(i);
      #1;
      check_eq($sformatf("starve_mem_ready_%0d", i), 32'(wb.mem_ready), 32'(exp_mem));
      check_eq($sformatf("starve_alu_ready_%0d", i), 32'(wb.alu_ready), 32'(!exp_mem));
      tick();
      check_eq($sformatf("starve_src_%0d", i), 32'(grant_src), 32'(exp_mem));
      check_eq($sformatf("starve_data_%0d", i), write_data,
               exp_mem ? (32'h2000_0000 + 32'(i)) : (32'h1000_0000 + 32'(i)));
    end
    idle_inputs();
    tick();

    // Same rd=9 from both: MEM first, then ALU, final value 0x1
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd9;
    wb.alu_data  = 32'h0000_0001;
    wb.mem_valid = 1'b1;
    wb.mem_rd    = 5'd9;
    wb.mem_data  = 32'h0000_0002;
    #1;
    check_eq("samerd_pending", pending, 32'h0000_0200);
    tick();
    wb.mem_valid = 1'b0;
    check_eq("samerd_n1_data", write_data, 32'h0000_0002);
    check_eq("samerd_n1_src", 32'(grant_src), 32'd1);
    #1;
    check_eq("samerd_alu_ready", 32'(wb.alu_ready), 32'd1);
    tick();
    idle_inputs();
    check_eq("samerd_n2_reg_write", 32'(reg_write), 32'd1);
    check_eq("samerd_n2_rd", 32'(rd), 32'd9);
    check_eq("samerd_n2_data", write_data, 32'h0000_0001);
    check_eq("samerd_n2_src", 32'(grant_src), 32'd0);
    tick();

    // ALU write to r0
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd0;
    wb.alu_data  = 32'h0000_0055;
    #1;
    check_eq("r0_alu_ready", 32'(wb.alu_ready), 32'd1);
`ifdef RF_R0_ZERO_EN
    check_eq("r0_pending_req", pending, 32'h0000_0000);
`else
    check_eq("r0_pending_req", pending, 32'h0000_0001);
`endif
    tick();
    idle_inputs();
    #1;
`ifdef RF_R0_ZERO_EN
    check_eq("r0_reg_write", 32'(reg_write), 32'd0);
    check_eq("r0_pending_port", pending, 32'h0000_0000);
`else
    check_eq("r0_reg_write", 32'(reg_write), 32'd1);
    check_eq("r0_rd", 32'(rd), 32'd0);
    check_eq("r0_write_data", write_data, 32'h0000_0055);
    check_eq("r0_pending_port", pending, 32'h0000_0001);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
